// File: rtl/hack_alu_pkg.sv
// Shared definitions for the Hack ALU: the default datapath width and the
// six-bit control word.
package hack_alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

endpackage

// File: rtl/hack_alu_prep.sv
// Operand preconditioning: optionally force the operand to zero, then
// optionally invert it. Purely combinational.
module hack_alu_prep #(
  parameter int WIDTH = hack_alu_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic             z,
  input  logic             n,
  output logic [WIDTH-1:0] b
);

  logic [WIDTH-1:0] a_zeroed;

  // Zeroing comes first, so z=1 with n=1 yields all ones.
  assign a_zeroed = z ? '0 : a;
  assign b        = n ? ~a_zeroed : a_zeroed;

endmodule

// File: rtl/hack_alu.sv
// Hack ALU with a single output register stage: out, zr and ng are captured
// together from one sampled operation, with out_valid marking fresh results.
module hack_alu
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
);

  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] xb;
  logic [WIDTH-1:0] yb;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] result;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  hack_alu_prep #(.WIDTH(WIDTH)) u_prep_x (
    .a (x),
    .z (ctrl.zx),
    .n (ctrl.nx),
    .b (xb)
  );

  hack_alu_prep #(.WIDTH(WIDTH)) u_prep_y (
    .a (y),
    .z (ctrl.zy),
    .n (ctrl.ny),
    .b (yb)
  );

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    r      = '0;
    result = '0;
    // The sum is truncated to WIDTH bits; the carry out is deliberately lost.
    if (ctrl.f) r = xb + yb;
    else        r = xb & yb;
    result = ctrl.no ? ~r : r;
  end

  // Flags are registered from the same result as out, so they never disagree.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= result;
      zr        <= (result == '0);
      ng        <= result[WIDTH-1];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: an arithmetic reference model checked every
// cycle, plus hand-computed vectors that pin the model itself.
module tb_hack_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         zx, nx, zy, ny, f, no;
  logic [W-1:0] out;
  logic         zr, ng, out_valid;

  hack_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_out;
  logic         exp_zr;
  logic         exp_ng;
  logic         exp_valid;
  bit           model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference result from the arithmetic definition: inversion as (2^W-1)-v,
  // addition modulo 2^W.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                           input logic [5:0] c);
    longint unsigned modv = 64'd1 << W;
    longint unsigned mask = modv - 1;
    longint unsigned xa, xbv, ya, ybv, rv, res;
    xa  = c[5] ? 0 : longint'(xi);
    xbv = c[4] ? mask - xa : xa;
    ya  = c[3] ? 0 : longint'(yi);
    ybv = c[2] ? mask - ya : ya;
    rv  = c[1] ? (xbv + ybv) % modv : (xbv & ybv);
    res = c[0] ? mask - rv : rv;
    return res[W-1:0];
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at the falling edge.
  task automatic step(input bit r, input bit v, input logic [W-1:0] xi,
                      input logic [W-1:0] yi, input logic [5:0] c);
    logic [W-1:0] res;
    rst = r; in_valid = v; x = xi; y = yi;
    {zx, nx, zy, ny, f, no} = c;
    @(posedge clk);
    if (r) begin
      exp_out = '0; exp_zr = 1'b1; exp_ng = 1'b0; exp_valid = 1'b0;
    end else if (v) begin
      res       = ref_alu(xi, yi, c);
      exp_out   = res;
      exp_zr    = (res == 0);
      exp_ng    = res[W-1];
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    model_on = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check("model_out",   32'(out),       32'(exp_out));
      check("model_zr",    32'(zr),        32'(exp_zr));
      check("model_ng",    32'(ng),        32'(exp_ng));
      check("model_valid", 32'(out_valid), 32'(exp_valid));
    end
  end

  task automatic lit(input string name, input logic [W-1:0] o, input logic z,
                     input logic n, input logic v);
    check({name, "_out"},   32'(out),       32'(o));
    check({name, "_zr"},    32'(zr),        32'(z));
    check({name, "_ng"},    32'(ng),        32'(n));
    check({name, "_valid"}, 32'(out_valid), 32'(v));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
    {zx, nx, zy, ny, f, no} = '0;

    step(1, 0, 16'h0000, 16'h0000, 6'b000000);
    step(0, 0, 16'hbeef, 16'hcafe, 6'b000010);
    lit("reset_idle", 16'h0000, 1'b1, 1'b0, 1'b0);

    step(0, 1, 16'h1234, 16'h4321, 6'b000000); lit("and",        16'h0220, 1'b0, 1'b0, 1'b1);
    step(0, 1, 16'h1234, 16'h4321, 6'b000010); lit("add",        16'h5555, 1'b0, 1'b0, 1'b1);
    step(0, 1, 16'h1234, 16'h4321, 6'b100000); lit("zx_and",     16'h0000, 1'b1, 1'b0, 1'b1);
    step(0, 1, 16'h1234, 16'h4321, 6'b010100); lit("nxny_and",   16'hacca, 1'b0, 1'b1, 1'b1);
    step(0, 1, 16'h1234, 16'h4321, 6'b010110); lit("nxny_add",   16'haaa9, 1'b0, 1'b1, 1'b1);
    step(0, 1, 16'h1234, 16'h4321, 6'b010111); lit("nxny_add_no", 16'h5556, 1'b0, 1'b0, 1'b1);
    step(0, 1, 16'h9a7c, 16'h0f31, 6'b111111); lit("all_ones",   16'h0001, 1'b0, 1'b0, 1'b1);
    step(0, 1, 16'h9a7c, 16'h0f31, 6'b111110); lit("minus_two",  16'hfffe, 1'b0, 1'b1, 1'b1);
    step(0, 1, 16'hffff, 16'h0001, 6'b000010); lit("wrap",       16'h0000, 1'b1, 1'b0, 1'b1);
    step(0, 0, 16'h1111, 16'h2222, 6'b000010); lit("hold_wrap",  16'h0000, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional resets and idle cycles.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom), 6'($urandom));
    end

    // Stream with a mid-stream reset, then go idle.
    step(0, 1, 16'h0f0f, 16'h00f0, 6'b000010); lit("stream_a",   16'h0fff, 1'b0, 1'b0, 1'b1);
    step(1, 1, 16'h1234, 16'h4321, 6'b000010); lit("stream_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(0, 1, 16'h1234, 16'h4321, 6'b000010); lit("stream_b",   16'h5555, 1'b0, 1'b0, 1'b1);
    step(0, 1, 16'h1234, 16'h4321, 6'b010110); lit("stream_c",   16'haaa9, 1'b0, 1'b1, 1'b1);
    step(0, 0, 16'h0000, 16'h0000, 6'b000000); lit("idle_1",     16'haaa9, 1'b0, 1'b1, 1'b0);
    step(0, 0, 16'hffff, 16'hffff, 6'b111111); lit("idle_2",     16'haaa9, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hack_alu.md
HACK_ALU -- requirements
Module: hack_alu

Interface
REQ-001 SHALL: parameter WIDTH, default 16, data path width in bits.
REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL: in_valid  input  1  x, y and control bits are sampled this cycle.
REQ-005 SHALL: x  input  WIDTH  operand X.
REQ-006 SHALL: y  input  WIDTH  operand Y.
REQ-007 SHALL: zx, nx  input  1 each  zero X, then bitwise-invert X.
REQ-008 SHALL: zy, ny  input  1 each  zero Y, then bitwise-invert Y.
REQ-009 SHALL: f  input  1  function select: 1 = add, 0 = bitwise AND.
REQ-010 SHALL: no  input  1  bitwise-invert the function result.
REQ-011 SHALL: out  output  WIDTH  registered result.
REQ-012 SHALL: zr  output  1  registered flag, 1 when out == 0.
REQ-013 SHALL: ng  output  1  registered flag, equal to out[WIDTH-1].
REQ-014 SHALL: out_valid  output  1  out/zr/ng hold a result sampled with in_valid.

Function
REQ-015 SHALL: xa = zx ? 0 : x; xb = nx ? ~xa : xa (zero before invert).
REQ-016 SHALL: ya = zy ? 0 : y; yb = ny ? ~ya : ya.
REQ-017 SHALL: r = f ? (xb + yb) mod 2^WIDTH : (xb & yb); carry out discarded, no overflow flag.
REQ-018 SHALL: result = no ? ~r : r; zr = (result == 0); ng = result[WIDTH-1].
REQ-019 SHALL: latency exactly 1 cycle: inputs sampled with in_valid at edge N appear on out/zr/ng at edge N with out_valid = 1 after that edge.
REQ-020 SHALL: cycles with in_valid = 0 leave out/zr/ng unchanged and clear out_valid to 0.
REQ-021 SHALL: back-to-back in_valid every cycle is supported; throughput is 1 result per cycle; no stall or backpressure.
REQ-022 SHALL: all 64 control combinations are legal, with no don't-care cases.
REQ-023 SHALL: zr and ng are always consistent with the registered out.

Reset
REQ-024 SHALL: when rst = 1 at a rising edge: out = 0, zr = 1, ng = 0, out_valid = 0.
REQ-025 SHALL: rst has priority over in_valid in the same cycle; that cycle's inputs are dropped.
REQ-026 SHALL: reset asserted mid-stream discards any pending result; first valid output follows the first in_valid after rst deasserts.

Structure
REQ-027 SHALL: shared package hack_alu_pkg holds the WIDTH default constant and a packed struct alu_ctrl_t {zx, nx, zy, ny, f, no}.
REQ-028 SHALL: one sub-module hack_alu_prep (combinational zero/invert of one operand) instantiated twice, for X and Y.
REQ-029 SHALL: the function, output invert and flag logic are combinational in the top level, followed by a single register stage.

Verification
REQ-030 SHALL: after reset with in_valid = 0 -> out = 0000, zr = 1, ng = 0, out_valid = 0.
REQ-031 SHALL: x = 1234, y = 4321, all controls 0 -> out 0220; f = 1 -> 5555; zx = 1, f = 0 -> 0000, zr = 1.
REQ-032 SHALL: x = 1234, y = 4321, nx = ny = 1, f = 0 -> ACCA, ng = 1; with f = 1 -> AAA9, ng = 1; with f = 1, no = 1 -> 5556, ng = 0.
REQ-033 SHALL: all six controls 1, any x, y -> out 0001; zx = zy = nx = ny = 1, f = 1, no = 0 -> FFFE, ng = 1.
REQ-034 SHALL: x = FFFF, y = 0001, f = 1 -> out 0000, zr = 1 (wrap-around, carry dropped).
REQ-035 SHALL: streaming in_valid = 1 with rst pulsed mid-stream, then in_valid low -> 1-cycle latency, reset values on the cycle after the rst edge, and held values with out_valid = 0 once in_valid is low.
